// File: rtl/write_line_scheduler_if.sv
// Bundle between layer controller, write_line_scheduler and write2control.
// slave = the scheduler's view; master = the environment driving it.
interface write_line_scheduler_if #(
  parameter int unsigned X_MAC        = 4,
  parameter int unsigned ADDR_LEN     = 13,
  parameter int unsigned MAX_LINE_LEN = 10,
  parameter int unsigned MAX_LINES    = 10
);
  logic                      i_start;
  logic [ADDR_LEN-1:0]       i_base_addr;
  logic [ADDR_LEN-1:0]       i_addr_step;
  logic [MAX_LINES-1:0]      i_num_lines;
  logic [MAX_LINE_LEN-1:0]   i_linelen_in;
  logic                      i_pooled_in;
  logic                      i_wr_idle;
  logic                      o_conf;
  logic [ADDR_LEN*X_MAC-1:0] o_st_addr;
  logic [MAX_LINE_LEN-1:0]   o_linelen;
  logic [1:0]                o_valid_mac;
  logic                      o_pooled;
  logic                      o_busy;
  logic                      o_done;

  modport slave (
    input  i_start, i_base_addr, i_addr_step, i_num_lines, i_linelen_in, i_pooled_in, i_wr_idle,
    output o_conf, o_st_addr, o_linelen, o_valid_mac, o_pooled, o_busy, o_done
  );

  modport master (
    output i_start, i_base_addr, i_addr_step, i_num_lines, i_linelen_in, i_pooled_in, i_wr_idle,
    input  o_conf, o_st_addr, o_linelen, o_valid_mac, o_pooled, o_busy, o_done
  );
endinterface

// File: rtl/write_line_scheduler.sv
// Walks one output tile line by line, issuing a conf pulse to write2control per line
// with start address / MAC column, and waiting for the writer to go idle in between.
module write_line_scheduler #(
  parameter int unsigned X_MAC        = 4,
  parameter int unsigned ADDR_LEN     = 13,
  parameter int unsigned MAX_LINE_LEN = 10,
  parameter int unsigned MAX_LINES    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  write_line_scheduler_if.slave bus
);
  localparam int unsigned MAC_W = 2;
  localparam int unsigned SUM_W = MAC_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAITW,
    S_CONF,
    S_GUARD,
    S_RUN,
    S_DONE
  } state_t;

  state_t                  r_state,     w_nxt_state;
  logic                    r_conf,      w_nxt_conf;
  logic                    r_done,      w_nxt_done;
  logic                    r_busy,      w_nxt_busy;
  logic [ADDR_LEN-1:0]     r_cur_addr,  w_nxt_cur_addr;
  logic [MAC_W-1:0]        r_valid_mac, w_nxt_valid_mac;
  logic [MAX_LINES-1:0]    r_line_cnt,  w_nxt_line_cnt;
  logic [ADDR_LEN-1:0]     r_addr_step, w_nxt_addr_step;
  logic [MAX_LINES-1:0]    r_num_lines, w_nxt_num_lines;
  logic [MAX_LINE_LEN-1:0] r_linelen,   w_nxt_linelen;
  logic                    r_pooled,    w_nxt_pooled;

  logic [MAX_LINES-1:0]    w_cnt_inc;
  logic [SUM_W-1:0]        w_mac_sum;
  logic                    w_mac_wrap;

  // Column advance: 1 column per line pooled, 2 columns unpooled; address steps on wrap
  assign w_cnt_inc  = r_line_cnt + MAX_LINES'(1);
  assign w_mac_sum  = SUM_W'(r_valid_mac) + (r_pooled ? SUM_W'(1) : SUM_W'(2));
  assign w_mac_wrap = (w_mac_sum >= SUM_W'(4));

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_conf      = 1'b0;
    w_nxt_done      = 1'b0;
    w_nxt_busy      = r_busy;
    w_nxt_cur_addr  = r_cur_addr;
    w_nxt_valid_mac = r_valid_mac;
    w_nxt_line_cnt  = r_line_cnt;
    w_nxt_addr_step = r_addr_step;
    w_nxt_num_lines = r_num_lines;
    w_nxt_linelen   = r_linelen;
    w_nxt_pooled    = r_pooled;

    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_nxt_busy      = 1'b1;
          w_nxt_cur_addr  = bus.i_base_addr;
          w_nxt_valid_mac = '0;
          w_nxt_line_cnt  = '0;
          w_nxt_addr_step = bus.i_addr_step;
          w_nxt_num_lines = bus.i_num_lines;
          w_nxt_linelen   = bus.i_linelen_in;
          w_nxt_pooled    = bus.i_pooled_in;
          w_nxt_state     = (bus.i_num_lines != '0) ? S_WAITW : S_DONE;
        end
      end

      S_WAITW: begin
        if (bus.i_wr_idle) begin
          w_nxt_state = S_CONF;
        end
      end

      S_CONF: begin
        w_nxt_conf  = 1'b1;
        w_nxt_state = S_GUARD;
      end

      // Writer raises its working flag one cycle after conf, so wr_idle is stale here
      S_GUARD: begin
        w_nxt_state = S_RUN;
      end

      S_RUN: begin
        if (bus.i_wr_idle) begin
          w_nxt_line_cnt = w_cnt_inc;
          if (w_cnt_inc == r_num_lines) begin
            w_nxt_state = S_DONE;
          end else begin
            w_nxt_state = S_CONF;
            if (w_mac_wrap) begin
              w_nxt_valid_mac = MAC_W'(w_mac_sum - SUM_W'(4));
              w_nxt_cur_addr  = r_cur_addr + r_addr_step;
            end else begin
              w_nxt_valid_mac = MAC_W'(w_mac_sum);
            end
          end
        end
      end

      S_DONE: begin
        w_nxt_done  = 1'b1;
        w_nxt_busy  = 1'b0;
        w_nxt_state = S_IDLE;
      end

      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_conf      <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_cur_addr  <= '0;
      r_valid_mac <= '0;
      r_line_cnt  <= '0;
      r_addr_step <= '0;
      r_num_lines <= '0;
      r_linelen   <= '0;
      r_pooled    <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_conf      <= w_nxt_conf;
      r_done      <= w_nxt_done;
      r_busy      <= w_nxt_busy;
      r_cur_addr  <= w_nxt_cur_addr;
      r_valid_mac <= w_nxt_valid_mac;
      r_line_cnt  <= w_nxt_line_cnt;
      r_addr_step <= w_nxt_addr_step;
      r_num_lines <= w_nxt_num_lines;
      r_linelen   <= w_nxt_linelen;
      r_pooled    <= w_nxt_pooled;
    end
  end

  // Every MAC column starts at the same address
  assign bus.o_conf      = r_conf;
  assign bus.o_st_addr   = {X_MAC{r_cur_addr}};
  assign bus.o_linelen   = r_linelen;
  assign bus.o_valid_mac = r_valid_mac;
  assign bus.o_pooled    = r_pooled;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
endmodule

// File: tb/tb_write_line_scheduler.sv
// Randomised bench for write_line_scheduler: a writer model answers each conf, and an
// arithmetic model of column/address progression predicts every line descriptor and timing.
module tb_write_line_scheduler;
  localparam int unsigned X_MAC        = 4;
  localparam int unsigned ADDR_LEN     = 13;
  localparam int unsigned MAX_LINE_LEN = 10;
  localparam int unsigned MAX_LINES    = 10;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  write_line_scheduler_if #(
    .X_MAC(X_MAC), .ADDR_LEN(ADDR_LEN), .MAX_LINE_LEN(MAX_LINE_LEN), .MAX_LINES(MAX_LINES)
  ) bus ();

  write_line_scheduler #(
    .X_MAC(X_MAC), .ADDR_LEN(ADDR_LEN), .MAX_LINE_LEN(MAX_LINE_LEN), .MAX_LINES(MAX_LINES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Line k sits at column position k*colstep across the mesh row; every 4 columns is one address step
  function automatic logic [1:0] model_vmac(input int k, input logic pooled);
    int pos;
    pos = k * (pooled ? 1 : 2);
    return 2'(pos % 4);
  endfunction

  function automatic logic [ADDR_LEN-1:0] model_addr(input int k, input logic [ADDR_LEN-1:0] base,
                                                     input logic [ADDR_LEN-1:0] step, input logic pooled);
    int pos;
    pos = k * (pooled ? 1 : 2);
    return ADDR_LEN'((int'(base) + (pos / 4) * int'(step)) % (1 << ADDR_LEN));
  endfunction

  task automatic run_tile(input string name, input logic [ADDR_LEN-1:0] base,
                          input logic [ADDR_LEN-1:0] step, input logic [MAX_LINES-1:0] lines,
                          input logic [MAX_LINE_LEN-1:0] llen, input logic pooled,
                          input int work, input int idle_delay, input bit scramble);
    int t, confs, exp_conf_t, exp_done_t, busy_left, budget;
    bit seen_done, exp_busy;
    logic [ADDR_LEN-1:0] prev_addr, ea;
    logic [1:0]          prev_vmac, ev;
    t = 0; confs = 0; busy_left = 0; seen_done = 1'b0;
    budget     = int'(lines) * (work + 6) + idle_delay + 20;
    exp_done_t = (lines == 0) ? 2 : -1;
    exp_conf_t = (lines == 0) ? -1 : ((idle_delay + 2 > 3) ? idle_delay + 2 : 3);
    bus.i_wr_idle     = (idle_delay == 0);
    bus.i_start       = 1'b1;
    bus.i_base_addr   = base;
    bus.i_addr_step   = step;
    bus.i_num_lines   = lines;
    bus.i_linelen_in  = llen;
    bus.i_pooled_in   = pooled;
    prev_addr = bus.o_st_addr[ADDR_LEN-1:0];
    prev_vmac = bus.o_valid_mac;
    while (!seen_done && t < budget) begin
      @(negedge clk);
      t++;
      bus.i_start = 1'b0;
      exp_busy = (t != exp_done_t);
      total++;
      if (bus.o_busy !== exp_busy) begin
        bad++;
        $display("FAIL %s busy t=%0d: got %b expected %b", name, t, bus.o_busy, exp_busy);
      end
      if (idle_delay > 0 && t == idle_delay) bus.i_wr_idle = 1'b1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          bus.i_wr_idle = 1'b1;
          if (confs == int'(lines)) exp_done_t = t + 2;
          else                      exp_conf_t = t + 2;
        end
      end
      if (bus.o_conf === 1'b1) begin
        ea = model_addr(confs, base, step, pooled);
        ev = model_vmac(confs, pooled);
        total++;
        if (t !== exp_conf_t) begin
          bad++;
          $display("FAIL %s conf_time line %0d: got t=%0d expected t=%0d", name, confs, t, exp_conf_t);
        end
        total++;
        if (confs >= int'(lines)) begin
          bad++;
          $display("FAIL %s conf_count: got conf #%0d expected at most %0d", name, confs + 1, lines);
        end
        total++;
        if (bus.o_st_addr !== {X_MAC{ea}}) begin
          bad++;
          $display("FAIL %s st_addr line %0d: got %h expected lanes of %0d", name, confs, bus.o_st_addr, ea);
        end
        total++;
        if (bus.o_valid_mac !== ev) begin
          bad++;
          $display("FAIL %s valid_mac line %0d: got %0d expected %0d", name, confs, bus.o_valid_mac, ev);
        end
        total++;
        if (bus.o_linelen !== llen || bus.o_pooled !== pooled) begin
          bad++;
          $display("FAIL %s linelen/pooled line %0d: got %0d/%b expected %0d/%b",
                   name, confs, bus.o_linelen, bus.o_pooled, llen, pooled);
        end
        total++;
        if (prev_addr !== ea || prev_vmac !== ev) begin
          bad++;
          $display("FAIL %s setup line %0d: got %0d/%0d before conf expected %0d/%0d",
                   name, confs, prev_addr, prev_vmac, ea, ev);
        end
        confs++;
        bus.i_wr_idle = 1'b0;
        busy_left     = work;
        exp_conf_t    = -1;
      end
      if (bus.o_done === 1'b1) begin
        total++;
        if (t !== exp_done_t || confs != int'(lines)) begin
          bad++;
          $display("FAIL %s done: got t=%0d confs=%0d expected t=%0d confs=%0d",
                   name, t, confs, exp_done_t, lines);
        end
        seen_done = 1'b1;
      end
      if (scramble && !seen_done) begin
        bus.i_start      = 1'($urandom);
        bus.i_base_addr  = ADDR_LEN'($urandom);
        bus.i_addr_step  = ADDR_LEN'($urandom);
        bus.i_num_lines  = MAX_LINES'($urandom);
        bus.i_linelen_in = MAX_LINE_LEN'($urandom);
        bus.i_pooled_in  = 1'($urandom);
      end
      prev_addr = bus.o_st_addr[ADDR_LEN-1:0];
      prev_vmac = bus.o_valid_mac;
    end
    total++;
    if (!seen_done) begin
      bad++;
      $display("FAIL %s timeout: got no done after %0d cycles expected done", name, t);
    end
    bus.i_start   = 1'b0;
    bus.i_wr_idle = 1'b1;
    @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, bus.o_done, bus.o_busy);
    end
  endtask

  task automatic test_reset;
    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_addr_step = '0; bus.i_num_lines = '0;
    bus.i_linelen_in = '0; bus.i_pooled_in = 1'b0; bus.i_wr_idle = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.o_conf !== 1'b0) begin bad++; $display("FAIL reset conf: got %b expected 0", bus.o_conf); end
    total++; if (bus.o_done !== 1'b0) begin bad++; $display("FAIL reset done: got %b expected 0", bus.o_done); end
    total++; if (bus.o_busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b expected 0", bus.o_busy); end
    total++; if (bus.o_st_addr !== '0) begin bad++; $display("FAIL reset st_addr: got %h expected 0", bus.o_st_addr); end
    total++; if (bus.o_linelen !== '0) begin bad++; $display("FAIL reset linelen: got %0d expected 0", bus.o_linelen); end
    total++; if (bus.o_valid_mac !== '0) begin bad++; $display("FAIL reset valid_mac: got %0d expected 0", bus.o_valid_mac); end
    total++; if (bus.o_pooled !== 1'b0) begin bad++; $display("FAIL reset pooled: got %b expected 0", bus.o_pooled); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pooled;
    run_tile("T1_pooled", 13'd100, 13'd8, 10'd6, 10'd40, 1'b1, 5, 0, 1'b0);
  endtask

  task automatic test_unpooled;
    run_tile("T2_unpooled", 13'd0, 13'd16, 10'd5, 10'd33, 1'b0, 5, 0, 1'b0);
  endtask

  task automatic test_zero_lines;
    run_tile("T3_zero", 13'd55, 13'd3, 10'd0, 10'd9, 1'b1, 5, 0, 1'b0);
  endtask

  task automatic test_wait_idle;
    run_tile("T4_wait", 13'd12, 13'd7, 10'd3, 10'd20, 1'b0, 4, 20, 1'b0);
  endtask

  task automatic test_wrap_ignore;
    run_tile("T5_wrap", 13'd8190, 13'd4, 10'd5, 10'd100, 1'b1, 3, 0, 1'b1);
  endtask

  task automatic test_mid_reset;
    int t, confs, rel;
    t = 0; confs = 0; rel = -1;
    bus.i_base_addr = 13'd300; bus.i_addr_step = 13'd20; bus.i_num_lines = 10'd5;
    bus.i_linelen_in = 10'd77; bus.i_pooled_in = 1'b1; bus.i_wr_idle = 1'b1; bus.i_start = 1'b1;
    while (confs < 3 && t < 100) begin
      @(negedge clk);
      t++;
      bus.i_start = 1'b0;
      if (t == rel) bus.i_wr_idle = 1'b1;
      if (bus.o_conf === 1'b1) begin
        confs++;
        bus.i_wr_idle = 1'b0;
        if (confs < 3) rel = t + 3;
      end
    end
    total++;
    if (confs != 3) begin bad++; $display("FAIL T6 reach_line3: got %0d confs expected 3", confs); end
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_busy !== 1'b1 || bus.o_valid_mac !== 2'd2 || bus.o_linelen !== 10'd77) begin
      bad++;
      $display("FAIL T6 pre_reset: got busy=%b vmac=%0d linelen=%0d expected 1/2/77",
               bus.o_busy, bus.o_valid_mac, bus.o_linelen);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus.o_busy !== 1'b0 || bus.o_st_addr !== '0 || bus.o_linelen !== '0 || bus.o_valid_mac !== '0 ||
        bus.o_pooled !== 1'b0 || bus.o_conf !== 1'b0 || bus.o_done !== 1'b0) begin
      bad++;
      $display("FAIL T6 async_reset: got busy=%b st=%h len=%0d vmac=%0d pooled=%b expected all 0",
               bus.o_busy, bus.o_st_addr, bus.o_linelen, bus.o_valid_mac, bus.o_pooled);
    end
    @(negedge clk);
    bus.i_wr_idle = 1'b1;
    total++;
    if (bus.o_done !== 1'b0 || bus.o_busy !== 1'b0) begin
      bad++;
      $display("FAIL T6 held_reset: got done=%b busy=%b expected 0/0", bus.o_done, bus.o_busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.o_done !== 1'b0) begin bad++; $display("FAIL T6 no_done: got done=%b expected 0", bus.o_done); end
    run_tile("T6_restart", 13'd40, 13'd5, 10'd3, 10'd12, 1'b0, 2, 0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      run_tile("rand", ADDR_LEN'($urandom), ADDR_LEN'($urandom), MAX_LINES'($urandom_range(0, 12)),
               MAX_LINE_LEN'($urandom), 1'($urandom), int'($urandom_range(1, 8)),
               int'($urandom_range(0, 4)), 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_pooled;
    test_unpooled;
    test_zero_lines;
    test_wait_idle;
    test_wrap_ignore;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
